// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding, master ids,
// slot map and address field layout.
package periph_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SLOT_W = 4;
    localparam int OFFS_W = ADDR_W - SLOT_W;

    // Slot map for the standard peripheral set.
    localparam logic [SLOT_W-1:0] SLOT_TIMER = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_UART  = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_GPIO  = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_SPARE = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_M0 = 2'd1,
        ST_GNT_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    function automatic logic [SLOT_W-1:0] addr_slot(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: SLOT_W];
    endfunction

    function automatic logic [OFFS_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFS_W-1:0];
    endfunction

endpackage

// File: rtl/periph_decoder.sv
// Combinational slot decode for the granted access: one-hot write strobes,
// read-data mux and out-of-range detection.
module periph_decoder
    import periph_pkg::*;
#(
    parameter int NUM_SLAVES = 4
) (
    input  logic                         active_i,
    input  logic                         we_i,
    input  logic [SLOT_W-1:0]            slot_i,
    input  logic [DATA_W*NUM_SLAVES-1:0] s_data_i,
    output logic [NUM_SLAVES-1:0]        s_we_o,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         slot_err_o
);

    logic                slot_valid;
    logic [DATA_W-1:0]   slot_rd [NUM_SLAVES];

    // Extra bit so NUM_SLAVES == 16 compares correctly.
    assign slot_valid = ({1'b0, slot_i} < 5'(NUM_SLAVES));
    assign slot_err_o = active_i & ~slot_valid;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            logic hit;
            assign hit         = (slot_i == SLOT_W'(gi));
            assign s_we_o[gi]  = active_i & we_i & hit;
            assign slot_rd[gi] = hit ? s_data_i[DATA_W*gi +: DATA_W] : '0;
        end
    endgenerate

    // At most one slot hits, so OR-ing the masked words forms the mux;
    // an out-of-range slot hits nothing and reads as zero.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            rd_data_o = rd_data_o | slot_rd[k];
        end
    end

endmodule

// File: rtl/periph_arbiter.sv
// Two-master peripheral bus arbiter: Moore grant FSM with alternating priority
// on contention, per-grant timeout and a decoded slave side.
module periph_arbiter
    import periph_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m0_req_i,
    input  logic [31:0]                  m0_addr_i,
    input  logic [31:0]                  m0_data_i,
    input  logic                         m0_we_i,
    output logic                         m0_gnt_o,
    output logic [31:0]                  m0_data_o,
    output logic                         m0_hold_o,
    input  logic                         m1_req_i,
    input  logic [31:0]                  m1_addr_i,
    input  logic [31:0]                  m1_data_i,
    input  logic                         m1_we_i,
    output logic                         m1_gnt_o,
    output logic [31:0]                  m1_data_o,
    output logic [31:0]                  s_addr_o,
    output logic [31:0]                  s_data_o,
    output logic [NUM_SLAVES-1:0]        s_we_o,
    input  logic [32*NUM_SLAVES-1:0]     s_data_i,
    output logic                         dec_err_o,
    output logic                         tout_o
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    master_e           last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tout_q, tout_d;
    logic              dec_err_q, dec_err_d;

    logic              granted;
    logic              sel_m1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_we;
    logic [DATA_W-1:0] rd_data;
    logic              slot_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= MST_M1;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            dec_err_q <= dec_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        tout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    state_d = (last_q == MST_M0) ? ST_GNT_M1 : ST_GNT_M0;
                end else if (m0_req_i) begin
                    state_d = ST_GNT_M0;
                end else if (m1_req_i) begin
                    state_d = ST_GNT_M1;
                end
            end
            ST_GNT_M0: begin
                // A dropped request wins over a coinciding timeout.
                if (!m0_req_i) begin
                    state_d = m1_req_i ? ST_GNT_M1 : ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    tout_d  = 1'b1;
                    state_d = m1_req_i ? ST_GNT_M1 : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GNT_M1: begin
                if (!m1_req_i) begin
                    state_d = m0_req_i ? ST_GNT_M0 : ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    tout_d  = 1'b1;
                    state_d = m0_req_i ? ST_GNT_M0 : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_GNT_M0) begin
                last_d = MST_M0;
            end else if (state_d == ST_GNT_M1) begin
                last_d = MST_M1;
            end
        end
    end

    assign granted = (state_q != ST_IDLE);
    assign sel_m1  = (state_q == ST_GNT_M1);

    // Granted master's request fields, forced to zero while idle.
    assign gnt_addr  = granted ? (sel_m1 ? m1_addr_i : m0_addr_i) : '0;
    assign gnt_wdata = granted ? (sel_m1 ? m1_data_i : m0_data_i) : '0;
    assign gnt_we    = granted & (sel_m1 ? m1_we_i : m0_we_i);

    periph_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decoder (
        .active_i   (granted),
        .we_i       (gnt_we),
        .slot_i     (addr_slot(gnt_addr)),
        .s_data_i   (s_data_i),
        .s_we_o     (s_we_o),
        .rd_data_o  (rd_data),
        .slot_err_o (slot_err)
    );

    assign dec_err_d = slot_err;

    assign m0_gnt_o  = (state_q == ST_GNT_M0);
    assign m1_gnt_o  = sel_m1;
    assign m0_hold_o = m0_req_i & ~m0_gnt_o;

    assign m0_data_o = m0_gnt_o ? rd_data : '0;
    assign m1_data_o = m1_gnt_o ? rd_data : '0;

    assign s_addr_o  = {{SLOT_W{1'b0}}, addr_offset(gnt_addr)};
    assign s_data_o  = gnt_wdata;

    assign dec_err_o = dec_err_q;
    assign tout_o    = tout_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, drop-at-timeout and reset-mid-grant.
module tb_periph_arbiter;
    import periph_pkg::*;

    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_hold, dec_err, tout;
    logic [31:0]   m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [NS-1:0] s_we;
    logic [32*NS-1:0] s_rdata;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [31:0] S0 = 32'hA000_0000;
    localparam logic [31:0] S1 = 32'hA000_0001;
    localparam logic [31:0] S2 = 32'hDEAD_BEEF;
    localparam logic [31:0] S3 = 32'hA000_0003;

    assign s_rdata = {S3, S2, S1, S0};

    periph_arbiter #(.NUM_SLAVES(NS), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req_i  (m0_req),
        .m0_addr_i (m0_addr),
        .m0_data_i (m0_wdata),
        .m0_we_i   (m0_we),
        .m0_gnt_o  (m0_gnt),
        .m0_data_o (m0_rdata),
        .m0_hold_o (m0_hold),
        .m1_req_i  (m1_req),
        .m1_addr_i (m1_addr),
        .m1_data_i (m1_wdata),
        .m1_we_i   (m1_we),
        .m1_gnt_o  (m1_gnt),
        .m1_data_o (m1_rdata),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_we_o    (s_we),
        .s_data_i  (s_rdata),
        .dec_err_o (dec_err),
        .tout_o    (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        e_g0;
        logic        e_g1;
        logic        e_hold;
        logic [3:0]  e_swe;
        logic [31:0] e_saddr;
        logic [31:0] e_sdata;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_derr;
        logic        e_tout;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_settle(input string nm);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        @(negedge clk);
        chk({nm, "_g0"}, 32'(m0_gnt), 32'h0);
        chk({nm, "_g1"}, 32'(m1_gnt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [99:0] g1h, g0h, th;
        logic [66:0] bg0, bt, bh;
        int          run;
        logic        seen;
        logic        tout_first;

        // m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata,
        // g0, g1, hold, swe, saddr, sdata, d0, d1, derr, tout
        vecs[0]  = '{1'b1, 1'b1, {SLOT_TIMER, 28'h8}, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, {SLOT_TIMER, 28'h8}, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b0, 4'b0001, 32'h8, 32'h10, S0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, {SLOT_GPIO, 28'h4}, 32'h0, 1'b1, 1'b1, {SLOT_UART, 28'h0}, 32'h55,
                     1'b1, 1'b0, 1'b0, 4'b0000, 32'h4, 32'h0, S2, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, {SLOT_UART, 28'h0}, 32'h55,
                     1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, S0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, {SLOT_UART, 28'h0}, 32'h55,
                     1'b0, 1'b1, 1'b0, 4'b0010, 32'h0, 32'h55, 32'h0, S1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, {SLOT_UART, 28'h0}, 32'h55,
                     1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h55, 32'h0, S1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, {4'h5, 28'h10}, 32'h0, 1'b1, 1'b1, {SLOT_SPARE, 28'h0}, 32'h77,
                     1'b0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, {4'h5, 28'h10}, 32'h0, 1'b1, 1'b1, {SLOT_SPARE, 28'h0}, 32'h77,
                     1'b1, 1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, {4'h5, 28'h10}, 32'h99, 1'b1, 1'b1, {SLOT_SPARE, 28'h0}, 32'h77,
                     1'b1, 1'b0, 1'b0, 4'b0000, 32'h10, 32'h99, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, {SLOT_SPARE, 28'h0}, 32'h77,
                     1'b0, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h77, 32'h0, S3, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, {SLOT_TIMER, 28'hC}, 32'h0, 1'b1, 1'b0, {SLOT_GPIO, 28'h0}, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, {SLOT_TIMER, 28'hC}, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b0, 4'b0000, 32'hC, 32'h0, S0, 32'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};

        // Reset with m0 requesting: everything idle, hold follows the request.
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_g0", 32'(m0_gnt), 32'h0);
        chk("rst_g1", 32'(m1_gnt), 32'h0);
        chk("rst_swe", 32'(s_we), 32'h0);
        chk("rst_d0", m0_rdata, 32'h0);
        chk("rst_derr", 32'(dec_err), 32'h0);
        chk("rst_tout", 32'(tout), 32'h0);
        chk("rst_hold", 32'(m0_hold), 32'h1);

        for (int i = 0; i < NV; i++) begin
            step();
            rst = 1'b0;
            drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
                  vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata);
            @(negedge clk);
            $display("vec %0d: g0=%b g1=%b hold=%b swe=%b saddr=%h sdata=%h d0=%h d1=%h derr=%b tout=%b",
                     i, m0_gnt, m1_gnt, m0_hold, s_we, s_addr, s_wdata, m0_rdata, m1_rdata, dec_err, tout);
            chk($sformatf("v%0d_g0", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
            chk($sformatf("v%0d_g1", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
            chk($sformatf("v%0d_hold", i), 32'(m0_hold), 32'(vecs[i].e_hold));
            chk($sformatf("v%0d_swe", i), 32'(s_we), 32'(vecs[i].e_swe));
            chk($sformatf("v%0d_saddr", i), s_addr, vecs[i].e_saddr);
            chk($sformatf("v%0d_sdata", i), s_wdata, vecs[i].e_sdata);
            chk($sformatf("v%0d_d0", i), m0_rdata, vecs[i].e_d0);
            chk($sformatf("v%0d_d1", i), m1_rdata, vecs[i].e_d1);
            chk($sformatf("v%0d_derr", i), 32'(dec_err), 32'(vecs[i].e_derr));
            chk($sformatf("v%0d_tout", i), 32'(tout), 32'(vecs[i].e_tout));
        end

        // M1 holds its request with M0 contending: 64 grant cycles, one timeout, then M0.
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            g1h[c] = m1_gnt;
            g0h[c] = m0_gnt;
            th[c]  = tout;
            step();
        end
        run = 0;
        seen = 1'b0;
        tout_first = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!seen && g1h[c]) run++;
            if (!seen && g0h[c]) begin
                seen = 1'b1;
                tout_first = th[c];
            end
        end
        $display("timeout_m1: m1 grant run=%0d tout pulses=%0d", run, $countones(th));
        chk("to_m1_run", 32'(run), 32'd64);
        chk("to_m1_pulses", 32'($countones(th)), 32'd1);
        chk("to_m0_granted", 32'(seen), 32'h1);
        chk("to_pulse_at_m0", 32'(tout_first), 32'h1);
        chk("to_m0_at_65", 32'(g0h[64]), 32'h1);
        idle_settle("to_m1_settle");

        // M0 alone times out to IDLE, then is granted again by the idle rules.
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            bg0[c] = m0_gnt;
            bt[c]  = tout;
            bh[c]  = m0_hold;
            step();
        end
        $display("timeout_idle: grant cycles=%0d tout pulses=%0d", $countones(bg0[64:1]), $countones(bt));
        chk("ti_idle_first", 32'(bg0[0]), 32'h0);
        chk("ti_run", 32'($countones(bg0[64:1])), 32'd64);
        chk("ti_revoked", 32'(bg0[65]), 32'h0);
        chk("ti_tout", 32'(bt[65]), 32'h1);
        chk("ti_hold", 32'(bh[65]), 32'h1);
        chk("ti_regrant", 32'(bg0[66]), 32'h1);
        chk("ti_pulses", 32'($countones(bt)), 32'd1);
        idle_settle("ti_settle");

        // Request drops in the same cycle the counter reaches its limit: no timeout.
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            bg0[c] = m0_gnt;
            bt[c]  = tout;
            step();
            if (c == 63) m0_req = 1'b0;
        end
        $display("drop_at_limit: grant cycles=%0d tout pulses=%0d", $countones(bg0), $countones(bt));
        chk("dl_last_grant", 32'(bg0[64]), 32'h1);
        chk("dl_run", 32'($countones(bg0)), 32'd64);
        chk("dl_no_tout", 32'($countones(bt)), 32'd0);
        idle_settle("dl_settle");

        // Reset while M0 holds a write grant.
        step();
        drive(1'b1, 1'b1, {SLOT_UART, 28'h20}, 32'hCAFE, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk("rm_g0_before", 32'(m0_gnt), 32'h1);
        chk("rm_swe_before", 32'(s_we), 32'b0010);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_g0_in_rst", 32'(m0_gnt), 32'h1);
        step();
        rst = 1'b0;
        @(negedge clk);
        $display("reset_mid_grant: g0=%b swe=%b tout=%b derr=%b", m0_gnt, s_we, tout, dec_err);
        chk("rm_g0_after", 32'(m0_gnt), 32'h0);
        chk("rm_swe_after", 32'(s_we), 32'h0);
        chk("rm_tout_after", 32'(tout), 32'h0);
        chk("rm_derr_after", 32'(dec_err), 32'h0);
        chk("rm_hold_after", 32'(m0_hold), 32'h1);
        chk("rm_s_addr_after", s_addr, 32'h0);
        step();
        @(negedge clk);
        chk("rm_regrant", 32'(m0_gnt), 32'h1);
        chk("rm_regrant_swe", 32'(s_we), 32'b0010);

        // Fresh reset then simultaneous requests: M0 wins the first contention.
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("pc_idle_g0", 32'(m0_gnt), 32'h0);
        chk("pc_idle_g1", 32'(m1_gnt), 32'h0);
        step();
        @(negedge clk);
        $display("post_reset_contention: g0=%b g1=%b", m0_gnt, m1_gnt);
        chk("pc_g0", 32'(m0_gnt), 32'h1);
        chk("pc_g1", 32'(m1_gnt), 32'h0);
        idle_settle("pc_settle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of decoded peripheral slots (1..16).
REQ-002 Parameter TIMEOUT, default 64, maximum consecutive grant cycles per master (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 m0_req_i / m1_req_i  input  1  bus request, master 0 (core) / master 1 (debug).
REQ-006 m0_addr_i / m1_addr_i  input  32  byte address; [31:28] slot select, [27:0] offset.
REQ-007 m0_data_i / m1_data_i  input  32  write data.
REQ-008 m0_we_i / m1_we_i  input  1  write enable.
REQ-009 m0_gnt_o / m1_gnt_o  output  1  grant; bus belongs to that master this cycle.
REQ-010 m0_data_o / m1_data_o  output  32  read data.
REQ-011 m0_hold_o  output  1  stall to core pipeline: m0_req_i & ~m0_gnt_o.
REQ-012 s_addr_o  output  32  {4'h0, granted addr[27:0]}.
REQ-013 s_data_o  output  32  granted master write data.
REQ-014 s_we_o  output  NUM_SLAVES  one-hot per-slot write strobe.
REQ-015 s_data_i  input  32*NUM_SLAVES  slot read data, slot k at bits [32k+31:32k].
REQ-016 dec_err_o  output  1  one-cycle pulse: granted access to slot >= NUM_SLAVES.
REQ-017 tout_o  output  1  one-cycle pulse: grant forcibly revoked by timeout.

Function
REQ-018 FSM states IDLE, GNT_M0, GNT_M1; gnt outputs decoded from state register only (Moore).
REQ-019 IDLE: only m0_req_i -> GNT_M0; only m1_req_i -> GNT_M1; both -> master other than last_q; none -> IDLE.
REQ-020 Grant latency: request seen in IDLE at cycle N -> gnt high at cycle N+1.
REQ-021 last_q updates to the granted master on every entry into a GNT state.
REQ-022 GNT_Mx with req_x high and cnt_q < TIMEOUT-1: stay, cnt_q increments.
REQ-023 GNT_Mx with req_x low: other req high -> directly to other GNT state (no IDLE bubble); else IDLE.
REQ-024 GNT_Mx with req_x high and cnt_q == TIMEOUT-1: tout_o pulses next cycle; go to other GNT state if its req high, else IDLE.
REQ-025 After timeout to IDLE, revoked master re-requesting is granted via normal IDLE rules.
REQ-026 req_x drop and timeout in same cycle: treated as drop; tout_o stays low.
REQ-027 cnt_q clears to 0 on every state transition and in IDLE; width clog2(TIMEOUT).
REQ-028 Slave side muxed from granted master; in IDLE s_addr_o, s_data_o = 0, s_we_o = 0.
REQ-029 s_we_o[k] = granted & granted_we & (addr[31:28] == k) & (k < NUM_SLAVES); combinational.
REQ-030 Granted master data_o = s_data_i slot addr[31:28], or 0 if slot >= NUM_SLAVES; ungranted master data_o = 0.
REQ-031 Out-of-range slot while granted: no write strobe, read 0, dec_err_o registered (pulse next cycle, each such cycle).
REQ-032 Read path combinational: same-cycle read data for slaves with combinational read.

Reset
REQ-033 rst high at any edge: state IDLE, cnt_q 0, last_q = M1 (first contention goes to M0), dec_err_o 0, tout_o 0.
REQ-034 During and immediately after reset all gnt, s_we_o, data_o, hold-independent outputs are 0; m0_hold_o follows m0_req_i.
REQ-035 Reset mid-grant drops grant at the reset edge; no tout_o or dec_err_o generated.

Structure
REQ-036 Shared package periph_pkg: state encoding, slot index constants (SLOT_TIMER=0, SLOT_UART=1, SLOT_GPIO=2, SLOT_SPARE=3), address field widths.
REQ-037 One sub-module periph_decoder: combinational slot decode, write-strobe and read-data mux; FSM and counter stay in periph_arbiter.

Verification
REQ-038 Reset then m0_req_i=1 only, addr 0x0000_0008, we=1, data 0x10: gnt at cycle 2, s_we_o=4'b0001, s_addr_o=0x8, m0_hold_o=1 only in cycle 1.
REQ-039 Both req from IDLE after reset: M0 granted first; M0 drops -> M1 granted next cycle, no IDLE gap; next contention from IDLE goes to M0.
REQ-040 M1 holds req for 100 cycles, M0 requesting, TIMEOUT=64: M1 granted 64 cycles, tout_o pulse once, M0 granted next.
REQ-041 Granted read addr 0x5000_0000 with NUM_SLAVES=4: data_o=0, s_we_o=0, dec_err_o pulse one cycle later.
REQ-042 Assert rst during GNT_M0 with write active: next cycle state IDLE, gnt 0, s_we_o 0, tout_o 0; re-request granted normally.
REQ-043 Read slot 2 with s_data_i slot2=0xDEADBEEF: granted data_o=0xDEADBEEF same cycle, other master data_o=0.
